// File: rtl/ysyx_23060203_ifu_fq_if.sv
// Fetch-queue bus: ICache lookup, EXU/CSR redirects and the IDU-facing queue head.
// The master side is the fetch unit; the slave side is its surroundings.
interface ysyx_23060203_ifu_fq_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      cache_addr;
  logic             cache_hit;
  logic [31:0]      cache_inst;
  logic             jump_flush;
  logic [31:0]      jump_dnpc;
  logic             cs_flush;
  logic [31:0]      cs_dnpc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_pred_taken;
  logic [31:0]      out_pred_npc;
  logic [CNT_W-1:0] fq_count;

  modport master (
    output cache_addr,
    input  cache_hit, cache_inst,
    input  jump_flush, jump_dnpc, cs_flush, cs_dnpc,
    output out_valid,
    input  out_ready,
    output out_pc, out_inst, out_pred_taken, out_pred_npc, fq_count
  );

  modport slave (
    input  cache_addr,
    output cache_hit, cache_inst,
    output jump_flush, jump_dnpc, cs_flush, cs_dnpc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_inst, out_pred_taken, out_pred_npc, fq_count
  );
endinterface

// File: rtl/ysyx_23060203_ifu_fq.sv
// Instruction-fetch front end with static next-PC prediction and a DEPTH-entry fetch queue.
// Define YSYX_IFU_JAL_PRED_EN to predict JAL taken; otherwise JAL is fetched sequentially.
module ysyx_23060203_ifu_fq #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  ysyx_23060203_ifu_fq_if.master   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] npc;
  } fq_entry_t;

  typedef enum logic {S_RUN, S_PEND} state_t;

  state_t           state, state_n;
  logic [31:0]      fetch_pc, pc_n;
  logic [31:0]      pend_pc, pend_pc_n;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rptr, wptr;
  fq_entry_t        mem [DEPTH];

  logic        flush, enq, deq, out_valid_c;
  logic [31:0] dnpc, pred_npc, imm_b, imm_j;
  logic        pred_taken;
  fq_entry_t   wr_entry;

  assign flush = bus.cs_flush | bus.jump_flush;
  assign dnpc  = bus.cs_flush ? bus.cs_dnpc : bus.jump_dnpc;
  assign imm_b = {{20{bus.cache_inst[31]}}, bus.cache_inst[7], bus.cache_inst[30:25],
                  bus.cache_inst[11:8], 1'b0};
  assign imm_j = {{12{bus.cache_inst[31]}}, bus.cache_inst[19:12], bus.cache_inst[20],
                  bus.cache_inst[30:21], 1'b0};

  // Static prediction: backward conditional branches taken, everything else sequential.
  always_comb begin
    pred_taken = 1'b0;
    pred_npc   = fetch_pc + 32'd4;
    if (bus.cache_inst[6:2] == 5'b11000 && bus.cache_inst[31]) begin
      pred_taken = 1'b1;
      pred_npc   = fetch_pc + imm_b;
    end
`ifdef YSYX_IFU_JAL_PRED_EN
    if (bus.cache_inst[6:2] == 5'b11011) begin
      pred_taken = 1'b1;
      pred_npc   = fetch_pc + imm_j;
    end
`endif
  end

  assign out_valid_c = (count != '0) & ~flush;
  assign deq         = out_valid_c & bus.out_ready;
  assign enq         = bus.cache_hit & ~flush & (state == S_RUN) &
                       ((count < CNT_W'(DEPTH)) | deq);
  assign wr_entry    = '{pc: fetch_pc, inst: bus.cache_inst, taken: pred_taken, npc: pred_npc};

  // Redirect tracking: a miss-time flush waits for the in-flight refill before retargeting.
  always_comb begin
    state_n   = state;
    pc_n      = fetch_pc;
    pend_pc_n = pend_pc;
    if (flush) begin
      if (bus.cache_hit) begin
        pc_n    = dnpc;
        state_n = S_RUN;
      end else begin
        pend_pc_n = dnpc;
        state_n   = S_PEND;
      end
    end else if (state == S_PEND) begin
      if (bus.cache_hit) begin
        pc_n    = pend_pc;
        state_n = S_RUN;
      end
    end else if (enq) begin
      pc_n = pred_npc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      pend_pc  <= pend_pc_n;
    end
  end

  // Queue storage; a flush wins over any simultaneous push or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      mem   <= '{default: '0};
    end else if (flush) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (deq) rptr <= rptr + PTR_W'(1);
      if (enq) begin
        mem[wptr] <= wr_entry;
        wptr      <= wptr + PTR_W'(1);
      end
    end
  end

  assign bus.cache_addr     = fetch_pc;
  assign bus.out_valid      = out_valid_c;
  assign bus.out_pc         = mem[rptr].pc;
  assign bus.out_inst       = mem[rptr].inst;
  assign bus.out_pred_taken = mem[rptr].taken;
  assign bus.out_pred_npc   = mem[rptr].npc;
  assign bus.fq_count       = count;
endmodule

// File: tb/tb_ysyx_23060203_ifu_fq.sv
// Bench for ysyx_23060203_ifu_fq: directed vector table, hand-written redirect/JAL sequences,
// then random traffic against a queue-based reference model.
module tb_ysyx_23060203_ifu_fq;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] B     = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ_B = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] BEQ_F = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] JAL40 = 32'h0400_006F;  // jal x0,+0x40

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ysyx_23060203_ifu_fq_if #(.DEPTH(DEPTH)) bus ();
  ysyx_23060203_ifu_fq #(.DEPTH(DEPTH), .RESET_PC(B)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        hit;
    logic [31:0] inst;
    logic        rdy;
    logic        jf;
    logic [31:0] jd;
    logic [31:0] e_addr;
    logic        e_valid;
    int          e_cnt;
    logic [31:0] e_pc;
    logic        e_tk;
    logic [31:0] e_npc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] npc;
  } ent_t;

  vec_t tbl [16];
  ent_t mq [$];
  logic [31:0] m_pc, m_pend_pc;
  logic        m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic hit, input logic [31:0] inst, input logic rdy,
                       input logic jf, input logic [31:0] jd,
                       input logic cf, input logic [31:0] cd);
    bus.cache_hit  = hit;
    bus.cache_inst = inst;
    bus.out_ready  = rdy;
    bus.jump_flush = jf;
    bus.jump_dnpc  = jd;
    bus.cs_flush   = cf;
    bus.cs_dnpc    = cd;
  endtask

  function automatic vec_t mk(logic hit, logic [31:0] inst, logic rdy, logic jf, logic [31:0] jd,
                              logic [31:0] ea, logic ev, int ec,
                              logic [31:0] ep, logic et, logic [31:0] en);
    vec_t v;
    v.hit = hit; v.inst = inst; v.rdy = rdy; v.jf = jf; v.jd = jd;
    v.e_addr = ea; v.e_valid = ev; v.e_cnt = ec; v.e_pc = ep; v.e_tk = et; v.e_npc = en;
    return v;
  endfunction

  // Reference prediction derived from the instruction-set immediate layouts.
  function automatic ent_t predict(logic [31:0] pc, logic [31:0] inst);
    ent_t e;
    logic signed [12:0] ob;
    logic signed [20:0] oj;
    ob = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    oj = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    e.pc = pc; e.inst = inst; e.tk = 1'b0; e.npc = pc + 32'd4;
    if (inst[6:2] == 5'b11000 && inst[31]) begin
      e.tk = 1'b1; e.npc = pc + 32'($signed(ob));
    end
`ifdef YSYX_IFU_JAL_PRED_EN
    if (inst[6:2] == 5'b11011) begin
      e.tk = 1'b1; e.npc = pc + 32'($signed(oj));
    end
`endif
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    m_pc = B; m_pend = 1'b0; m_pend_pc = 32'h0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w = NOP;
      1: begin w[6:0] = 7'h63; w[31] = 1'b1; end
      2: begin w[6:0] = 7'h63; w[31] = 1'b0; end
      3: w[6:0] = 7'h6F;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    ent_t  p;
    logic  hit, rdy, jf, cf, flush, ev, dq, eq;
    logic [31:0] inst, jd, cd, dnpc;

    // Reset values
    do_reset();
    #1;
    chk("rst_addr", bus.cache_addr, B);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.fq_count), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_inst", bus.out_inst, 32'd0);
    chk("rst_tk", 32'(bus.out_pred_taken), 32'd0);
    chk("rst_npc", bus.out_pred_npc, 32'd0);

    // Directed table: sequential stream, branches, saturation, redirect with hit
    tbl[0]  = mk(1, NOP,   1, 0, 0,        B+32'h00,  0, 0, 0,         0, 0);
    tbl[1]  = mk(1, NOP,   1, 0, 0,        B+32'h04,  1, 1, B+32'h00,  0, B+32'h04);
    tbl[2]  = mk(1, NOP,   1, 0, 0,        B+32'h08,  1, 1, B+32'h04,  0, B+32'h08);
    tbl[3]  = mk(1, NOP,   1, 0, 0,        B+32'h0C,  1, 1, B+32'h08,  0, B+32'h0C);
    tbl[4]  = mk(1, BEQ_B, 1, 0, 0,        B+32'h10,  1, 1, B+32'h0C,  0, B+32'h10);
    tbl[5]  = mk(1, NOP,   1, 0, 0,        B+32'h08,  1, 1, B+32'h10,  1, B+32'h08);
    tbl[6]  = mk(1, BEQ_F, 1, 0, 0,        B+32'h0C,  1, 1, B+32'h08,  0, B+32'h0C);
    tbl[7]  = mk(1, NOP,   0, 0, 0,        B+32'h10,  1, 1, B+32'h0C,  0, B+32'h10);
    tbl[8]  = mk(1, NOP,   0, 0, 0,        B+32'h14,  1, 2, B+32'h0C,  0, B+32'h10);
    tbl[9]  = mk(1, NOP,   0, 0, 0,        B+32'h18,  1, 3, B+32'h0C,  0, B+32'h10);
    tbl[10] = mk(1, NOP,   0, 0, 0,        B+32'h1C,  1, 4, B+32'h0C,  0, B+32'h10);
    tbl[11] = mk(1, NOP,   1, 0, 0,        B+32'h1C,  1, 4, B+32'h0C,  0, B+32'h10);
    tbl[12] = mk(1, NOP,   0, 0, 0,        B+32'h20,  1, 4, B+32'h10,  0, B+32'h14);
    tbl[13] = mk(1, NOP,   1, 1, B+32'h100, B+32'h20, 0, 4, 0,         0, 0);
    tbl[14] = mk(1, NOP,   1, 0, 0,        B+32'h100, 0, 0, 0,         0, 0);
    tbl[15] = mk(1, NOP,   1, 0, 0,        B+32'h104, 1, 1, B+32'h100, 0, B+32'h104);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].hit, tbl[i].inst, tbl[i].rdy, tbl[i].jf, tbl[i].jd, 1'b0, 32'h0);
      #1;
      chk($sformatf("tbl%0d_addr", i), bus.cache_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 32'(bus.fq_count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), bus.out_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_tk", i), 32'(bus.out_pred_taken), 32'(tbl[i].e_tk));
        chk($sformatf("tbl%0d_npc", i), bus.out_pred_npc, tbl[i].e_npc);
      end
      tick();
    end

    // Flush during a miss, overridden by a CSR flush, resolved by a later hit
    drive(1'b0, NOP, 1'b1, 1'b1, B+32'h300, 1'b0, 32'h0);
    #1;
    chk("pend_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("pend_flush_addr", bus.cache_addr, B+32'h108);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("pend_count", 32'(bus.fq_count), 32'd0);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b1, B+32'h300, 1'b1, B+32'h200);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pend_hold%0d", i), bus.cache_addr, B+32'h108);
      tick();
    end
    drive(1'b1, NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("pend_hit_addr", bus.cache_addr, B+32'h108);
    tick();
    #1;
    chk("pend_target_addr", bus.cache_addr, B+32'h200);
    chk("pend_drop_count", 32'(bus.fq_count), 32'd0);
    tick();
    drive(1'b0, NOP, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("pend_head_pc", bus.out_pc, B+32'h200);
    chk("pend_head_valid", 32'(bus.out_valid), 32'd1);
    chk("pend_next_addr", bus.cache_addr, B+32'h204);
    tick();

    // JAL at the reset PC
    do_reset();
    drive(1'b1, JAL40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, NOP, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
`ifdef YSYX_IFU_JAL_PRED_EN
    chk("jal_addr", bus.cache_addr, B+32'h40);
    chk("jal_tk", 32'(bus.out_pred_taken), 32'd1);
`else
    chk("jal_addr", bus.cache_addr, B+32'h04);
    chk("jal_tk", 32'(bus.out_pred_taken), 32'd0);
`endif
    chk("jal_count", 32'(bus.fq_count), 32'd1);
    chk("jal_pc", bus.out_pc, B);

    // Random traffic against the reference model, with one mid-run reset
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) begin
        do_reset();
        #1;
        chk("rand_rst_count", 32'(bus.fq_count), 32'd0);
        chk("rand_rst_addr", bus.cache_addr, B);
      end
      hit  = ($urandom_range(0, 9) < 7);
      inst = rand_inst();
      rdy  = ($urandom_range(0, 9) < 6);
      jf   = ($urandom_range(0, 99) < 5);
      cf   = ($urandom_range(0, 99) < 3);
      jd   = B + (32'($urandom_range(0, 255)) << 2);
      cd   = B + (32'($urandom_range(0, 255)) << 2);
      drive(hit, inst, rdy, jf, jd, cf, cd);
      #1;
      flush = cf | jf;
      dnpc  = cf ? cd : jd;
      ev    = (mq.size() != 0) && !flush;
      chk("rand_addr", bus.cache_addr, m_pc);
      chk("rand_valid", 32'(bus.out_valid), 32'(ev));
      chk("rand_count", 32'(bus.fq_count), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("rand_pc", bus.out_pc, mq[0].pc);
        chk("rand_inst", bus.out_inst, mq[0].inst);
        chk("rand_tk", 32'(bus.out_pred_taken), 32'(mq[0].tk));
        chk("rand_npc", bus.out_pred_npc, mq[0].npc);
      end
      if (flush) begin
        mq.delete();
        if (hit) begin m_pc = dnpc; m_pend = 1'b0; end
        else begin m_pend = 1'b1; m_pend_pc = dnpc; end
      end else begin
        dq = ev && rdy;
        eq = hit && !m_pend && (mq.size() < DEPTH || dq);
        if (m_pend && hit) begin m_pc = m_pend_pc; m_pend = 1'b0; end
        if (dq) void'(mq.pop_front());
        if (eq) begin
          p = predict(m_pc, inst);
          mq.push_back(p);
          m_pc = p.npc;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
